// File: rtl/dmem_if.sv
// dmem_if: request/response channel between a requester (CPU MEM stage or a
// bus master) and the data-memory responder.
//   Request  : req_valid/req_ready handshake carrying req_we, req_addr,
//              req_wdata and req_wstrb (byte-lane enables, store only).
//   Response : rsp_valid/rsp_ready handshake carrying rsp_rdata and rsp_err.
// The master modport belongs to the requester and the slave modport to the
// responder.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data memory with a configurable number of wait
// states. One request is in flight at a time: it is accepted in IDLE, held
// through WAIT_CYCLES wait states, committed to memory on the transition into
// RESP, and its result is held in RESP until the requester takes it.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (memory contents are kept)
//   bus  - dmem_if.slave: request channel in, response channel out
// Parameters:
//   DEPTH_WORDS - number of 32-bit words (power of two)
//   BASE_ADDR   - byte address of word 0, aligned to DEPTH_WORDS*4
//   WAIT_CYCLES - wait states between accept and response (0..15)
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
);

   localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_reg;
   logic [3:0]  wait_cnt_reg;
   logic        hold_we_reg;
   logic [31:0] hold_addr_reg;
   logic [31:0] hold_wdata_reg;
   logic [3:0]  hold_wstrb_reg;
   logic        req_ready_reg;
   logic        rsp_valid_reg;
   logic [31:0] rsp_rdata_reg;
   logic        rsp_err_reg;

   logic [31:0] mem [DEPTH_WORDS];

   // The access is normally taken from the holding registers. With no wait
   // states the commit happens in the accept cycle itself, before the holding
   // registers are loaded, so the live request inputs are used instead.
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_wstrb;
   logic [32:0] acc_off;
   logic        acc_err;
   logic [IDX_W-1:0] acc_idx;
   logic        commit;
   logic        mem_we;
   logic [3:0]  lane_we;

   assign acc_we    = (state_reg == IDLE) ? bus.req_we    : hold_we_reg;
   assign acc_addr  = (state_reg == IDLE) ? bus.req_addr  : hold_addr_reg;
   assign acc_wdata = (state_reg == IDLE) ? bus.req_wdata : hold_wdata_reg;
   assign acc_wstrb = (state_reg == IDLE) ? bus.req_wstrb : hold_wstrb_reg;

   // 33-bit offset: an address below BASE_ADDR borrows into bit 32 and so
   // compares above SPAN, which folds both range checks into one compare.
   assign acc_off = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_off >= SPAN);
   assign acc_idx = acc_off[IDX_W+1:2];

   // Commit is the single cycle in which the FSM moves into RESP; reset
   // suppresses it so an aborted store never reaches memory.
   assign commit = !rst &&
                   ((NO_WAIT && (state_reg == IDLE) && bus.req_valid) ||
                    ((state_reg == WAIT) && (wait_cnt_reg == 4'd0)));
   assign mem_we = commit && acc_we && !acc_err;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_we[gi] = mem_we && acc_wstrb[gi];
      end
   endgenerate

   // Memory array: byte-lane writes, no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lane_we[i]) begin
            mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         wait_cnt_reg   <= 4'd0;
         hold_we_reg    <= 1'b0;
         hold_addr_reg  <= 32'h0;
         hold_wdata_reg <= 32'h0;
         hold_wstrb_reg <= 4'h0;
         req_ready_reg  <= 1'b1;
         rsp_valid_reg  <= 1'b0;
         rsp_rdata_reg  <= 32'h0;
         rsp_err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.req_valid) begin
                  hold_we_reg    <= bus.req_we;
                  hold_addr_reg  <= bus.req_addr;
                  hold_wdata_reg <= bus.req_wdata;
                  hold_wstrb_reg <= bus.req_wstrb;
                  req_ready_reg  <= 1'b0;
                  state_reg      <= WAIT;
                  wait_cnt_reg   <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (wait_cnt_reg != 4'd0) begin
                  wait_cnt_reg <= wait_cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state_reg     <= IDLE;
                  req_ready_reg <= 1'b1;
                  rsp_valid_reg <= 1'b0;
                  rsp_rdata_reg <= 32'h0;
                  rsp_err_reg   <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // Overrides the WAIT entry above when there are no wait states.
         if (commit) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= acc_err;
            rsp_rdata_reg <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'h0;
         end
      end
   end

   assign bus.req_ready = req_ready_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: four responder instances (WAIT_CYCLES = 1, 0, 3, 15).
// Instance 0 runs a table of load/store vectors plus a backpressure sequence;
// the others cover latency and reset-in-WAIT behaviour.
module tb_dmem_responder;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a       [N];
   logic        req_valid_a [N];
   logic        req_we_a    [N];
   logic [31:0] req_addr_a  [N];
   logic [31:0] req_wdata_a [N];
   logic [3:0]  req_wstrb_a [N];
   logic        rsp_ready_a [N];
   logic        req_ready_a [N];
   logic        rsp_valid_a [N];
   logic [31:0] rsp_rdata_a [N];
   logic        rsp_err_a   [N];

   int errors = 0;
   int checks = 0;

   function automatic int w_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 3 : 15;
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         localparam int unsigned W = (gi == 0) ? 1 : (gi == 1) ? 0 : (gi == 2) ? 3 : 15;
         dmem_if bus ();
         assign bus.req_valid   = req_valid_a[gi];
         assign bus.req_we      = req_we_a[gi];
         assign bus.req_addr    = req_addr_a[gi];
         assign bus.req_wdata   = req_wdata_a[gi];
         assign bus.req_wstrb   = req_wstrb_a[gi];
         assign bus.rsp_ready   = rsp_ready_a[gi];
         assign req_ready_a[gi] = bus.req_ready;
         assign rsp_valid_a[gi] = bus.rsp_valid;
         assign rsp_rdata_a[gi] = bus.rsp_rdata;
         assign rsp_err_a[gi]   = bus.rsp_err;

         dmem_responder #(
            .DEPTH_WORDS (1024),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_CYCLES (W)
         ) dut (
            .clk (clk),
            .rst (rst_a[gi]),
            .bus (bus.slave)
         );
      end
   endgenerate

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   // One full transaction on instance i. lat counts cycles from the accept
   // edge to the first cycle with rsp_valid high; busy_ok is cleared if
   // req_ready is seen high anywhere in that window.
   task automatic txn(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      output logic [31:0] rdata, output logic err,
                      output int lat, output logic busy_ok);
      @(negedge clk);
      check1($sformatf("inst%0d req_ready before accept", i), req_ready_a[i], 1'b1);
      req_we_a[i]    = we;
      req_addr_a[i]  = addr;
      req_wdata_a[i] = wdata;
      req_wstrb_a[i] = wstrb;
      req_valid_a[i] = 1'b1;
      @(posedge clk);
      #1;
      // Scramble the request lines; the accepted request must be unaffected.
      req_valid_a[i] = 1'b0;
      req_we_a[i]    = ~we;
      req_addr_a[i]  = 32'h0000_0022;
      req_wdata_a[i] = ~wdata;
      req_wstrb_a[i] = ~wstrb;
      lat     = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (req_ready_a[i]) busy_ok = 1'b0;
      end while (!rsp_valid_a[i] && lat < 40);
      check1($sformatf("inst%0d rsp_valid arrives", i), rsp_valid_a[i], 1'b1);
      rdata = rsp_rdata_a[i];
      err   = rsp_err_a[i];
      $display("inst%0d %s addr=%08h wdata=%08h wstrb=%h -> rdata=%08h err=%0b lat=%0d",
               i, we ? "ST" : "LD", addr, wdata, wstrb, rdata, err, lat);
      rsp_ready_a[i] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_a[i] = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [17];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        bo;
      logic        quiet;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0030, 32'h1234_5678, 4'h0, 32'h0000_0000, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0030, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0000, 32'h0000_0A0A, 4'hF, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
      vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0A0A, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h5A5A_5A5A, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      vecs[15] = '{1'b1, 32'h0000_0011, 32'h7777_7777, 4'hF, 32'h0000_0000, 1'b1};
      vecs[16] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};

      for (int i = 0; i < N; i++) begin
         rst_a[i]       = 1'b1;
         req_valid_a[i] = 1'b0;
         req_we_a[i]    = 1'b0;
         req_addr_a[i]  = 32'h0;
         req_wdata_a[i] = 32'h0;
         req_wstrb_a[i] = 4'h0;
         rsp_ready_a[i] = 1'b0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check1($sformatf("inst%0d reset req_ready", i), req_ready_a[i], 1'b1);
         check1($sformatf("inst%0d reset rsp_valid", i), rsp_valid_a[i], 1'b0);
         check32($sformatf("inst%0d reset rsp_rdata", i), rsp_rdata_a[i], 32'h0);
         check1($sformatf("inst%0d reset rsp_err", i), rsp_err_a[i], 1'b0);
         rst_a[i] = 1'b0;
      end

      // Vector table on the WAIT_CYCLES=1 instance
      for (int k = 0; k < 17; k++) begin
         txn(0, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, rd, er, lat, bo);
         check32($sformatf("vec%0d rdata", k), rd, vecs[k].exp_rdata);
         check1($sformatf("vec%0d err", k), er, vecs[k].exp_err);
         check32($sformatf("vec%0d latency", k), 32'(lat), 32'd2);
         check1($sformatf("vec%0d req_ready low while busy", k), bo, 1'b1);
      end

      // Latency sweep on WAIT_CYCLES = 0, 3, 15
      for (int i = 1; i < N; i++) begin
         txn(i, 1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, er, lat, bo);
         check32($sformatf("inst%0d latency", i), 32'(lat), 32'(w_of(i) + 1));
         check1($sformatf("inst%0d req_ready low while busy", i), bo, 1'b1);
         check1($sformatf("inst%0d sweep err", i), er, 1'b0);
         @(negedge clk);
         check1($sformatf("inst%0d req_ready after handshake", i), req_ready_a[i], 1'b1);
         check1($sformatf("inst%0d rsp_valid after handshake", i), rsp_valid_a[i], 1'b0);
      end

      // Reset during WAIT on WAIT_CYCLES=3: the pending store must be lost
      txn(2, 1'b1, 32'h0000_0040, 32'h0, 4'hF, rd, er, lat, bo);
      check1("rstwait preload err", er, 1'b0);
      @(negedge clk);
      req_we_a[2]    = 1'b1;
      req_addr_a[2]  = 32'h0000_0040;
      req_wdata_a[2] = 32'h0000_0055;
      req_wstrb_a[2] = 4'hF;
      req_valid_a[2] = 1'b1;
      @(posedge clk);
      #1;
      req_valid_a[2] = 1'b0;
      @(negedge clk);
      check1("rstwait in WAIT req_ready", req_ready_a[2], 1'b0);
      // rst and req_valid together: rst must win
      rst_a[2]       = 1'b1;
      req_valid_a[2] = 1'b1;
      repeat (2) @(negedge clk);
      rst_a[2]       = 1'b0;
      req_valid_a[2] = 1'b0;
      check1("rstwait post-reset req_ready", req_ready_a[2], 1'b1);
      check1("rstwait post-reset rsp_valid", rsp_valid_a[2], 1'b0);
      quiet = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid_a[2]) quiet = 1'b0;
      end
      check1("rstwait no stray response", quiet, 1'b1);
      txn(2, 1'b0, 32'h0000_0040, 32'h0, 4'h0, rd, er, lat, bo);
      check32("rstwait load 0x40", rd, 32'h0);
      check1("rstwait load err", er, 1'b0);

      // Backpressure on WAIT_CYCLES=1: load 0x10 held while a store waits
      @(negedge clk);
      req_we_a[0]    = 1'b0;
      req_addr_a[0]  = 32'h0000_0010;
      req_wstrb_a[0] = 4'h0;
      req_valid_a[0] = 1'b1;
      @(posedge clk);
      #1;
      req_we_a[0]    = 1'b1;
      req_wdata_a[0] = 32'h0BAD_C0DE;
      req_wstrb_a[0] = 4'hF;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid_a[0] && lat < 40);
      check32("bp first latency", 32'(lat), 32'd2);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         check32($sformatf("bp cyc%0d rdata", c), rsp_rdata_a[0], 32'hDEAD_BEEF);
         check32($sformatf("bp cyc%0d valid/ready/err", c),
                 {29'h0, rsp_valid_a[0], req_ready_a[0], rsp_err_a[0]}, 32'b100);
      end
      $display("inst0 LD addr=00000010 held 10 cycles rdata=%08h err=%0b", rsp_rdata_a[0], rsp_err_a[0]);
      rsp_ready_a[0] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_a[0] = 1'b0;
      @(negedge clk);
      check1("bp after handshake req_ready", req_ready_a[0], 1'b1);
      check1("bp after handshake rsp_valid", rsp_valid_a[0], 1'b0);
      check32("bp after handshake rdata", rsp_rdata_a[0], 32'h0);
      @(posedge clk);
      #1;
      req_valid_a[0] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid_a[0] && lat < 40);
      check32("bp second latency", 32'(lat), 32'd2);
      check1("bp second err", rsp_err_a[0], 1'b0);
      check32("bp second rdata", rsp_rdata_a[0], 32'h0);
      $display("inst0 ST addr=00000010 wdata=0badc0de wstrb=f -> err=%0b lat=%0d", rsp_err_a[0], lat);
      rsp_ready_a[0] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_a[0] = 1'b0;
      txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lat, bo);
      check32("bp readback", rd, 32'h0BAD_C0DE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder serving load/store requests from the CPU's MEM stage, or from a future bus master.
- Replaces the zero-wait Data_mem model when variable memory latency is needed.
- Accepts one request at a time on a valid/ready request channel.
- Inserts a configurable number of wait states, then returns read data or a write acknowledgement on a valid/ready response channel.
- Reports misaligned or out-of-range accesses as errors.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 1: wait states between accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables for a store; bit i selects wdata[8i+7:8i]; ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- Single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait counter=0. Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: capture we, addr, wdata and wstrb into holding registers.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - req_ready=0.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - At 0, perform the access and go to RESP.
- Access commit: happens on the transition into RESP, in that single cycle only.
  - Error condition: err = (addr[1:0]!=0) or (addr < BASE_ADDR) or (addr >= BASE_ADDR + DEPTH_WORDS*4).
  - Word index = (addr - BASE_ADDR) >> 2.
  - Load, no error: rsp_rdata is registered with mem[index].
  - Store, no error: write only the lanes enabled by wstrb. wstrb=4'b0000 writes nothing and is not an error. rsp_rdata=0.
  - Error: no memory write, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid drops next cycle, rsp_err and rsp_rdata clear to 0, FSM returns to IDLE.
- Latency: request accepted in cycle T gives rsp_valid first high in cycle T+1+WAIT_CYCLES.
- Throughput: minimum request spacing is WAIT_CYCLES+2 cycles. No request is accepted in the cycle of a response handshake.
- Backpressure: rsp_ready may stay low indefinitely. The response is held and no new request is accepted.
- Request inputs outside the IDLE accept cycle are ignored. Changes to req_* after acceptance have no effect.
- Read-after-write: a load accepted after a store's response handshake returns the stored data.
- Reset mid-operation:
  - Reset in WAIT aborts a pending store; memory is unchanged.
  - Reset in RESP drops the response; a store already committed remains written.
  - The FSM is in IDLE the cycle after rst deasserts.
- Simultaneous rst and req_valid: rst wins and the request is not accepted.

Test Plan:
1. Store then load, WAIT_CYCLES=1: store addr 0x10, data 0xDEADBEEF, wstrb 4'hF -> rsp_valid at T+2, err=0. Then load 0x10 -> rdata 0xDEADBEEF.
2. Partial store: word at 0x20 holds 0x11223344; store wdata 0xAABBCCDD with wstrb 4'b0101 -> a subsequent load of 0x20 returns 0x11BB33DD.
3. Errors: load 0x22 -> err=1, rdata=0. Store to BASE_ADDR+DEPTH_WORDS*4 (0x1000) -> err=1 and no memory word changes. Store with wstrb=0 to 0x30 -> err=0 and the word is unchanged.
4. Latency sweep WAIT_CYCLES=0,3,15 -> rsp_valid first high at T+1, T+4, T+16. req_ready is low from T+1 until the cycle after the response handshake.
5. Backpressure: hold rsp_ready=0 for 10 cycles while req_valid=1 with new requests -> rsp_valid, rdata and err stay constant and no second request is accepted. Raise rsp_ready -> handshake, then the next request is accepted 2 cycles later.
6. Reset mid-op: store 0x55 to 0x40 (old value 0x0), assert rst during WAIT (WAIT_CYCLES=3) -> after reset req_ready=1, rsp_valid=0, and a load of 0x40 returns 0x0.
